// File: rtl/stepper_phase_decoder.sv
// Stepper coil phase monitor. Decodes the 4-bit phase bus from the motor
// driver into steps, and tracks signed position, direction and step period.
// Illegal codes and skipped phases are flagged. Stall is reported when the
// decoder is unlocked or no step has arrived within STALL_CYC cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_INIT | waiting for a filtered legal pattern to use as phase reference
// ST_TRACK| locked: each filtered pattern change is decoded as a step
// ST_FAULT| illegal code or skipped phase seen; input ignored until CLR_POS
module stepper_phase_decoder #(
   parameter int POS_W      = 16,
   parameter int PER_W      = 24,
   parameter int STABLE_CYC = 4,
   parameter int STALL_CYC  = 1920000
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [3:0]              PHASE_IN,
   input  logic                    CLR_POS,
   output logic signed [POS_W-1:0] POSITION,
   output logic                    DIR,
   output logic                    STEP_PULSE,
   output logic [PER_W-1:0]        SPEED_PERIOD,
   output logic                    LOCKED,
   output logic                    ERR_ILLEGAL,
   output logic                    STALLED
);

   typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

   localparam logic [3:0]       STAB_TH  = 4'(STABLE_CYC);
   localparam logic [PER_W-1:0] STALL_TH = PER_W'(STALL_CYC);
   localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

   logic [3:0]       sync1, sync2;
   logic [1:0]       sync_fill;
   logic [3:0]       cand;
   logic [3:0]       stab_cnt, stab_nxt;
   logic [3:0]       filt;
   logic             filt_vld;

   state_t           state;
   logic [1:0]       idx;
   logic [1:0]       new_idx;
   logic [1:0]       delta;
   logic             legal;
   logic             first_pend;
   logic [PER_W-1:0] per_cnt, per_inc;

   // Count consecutive equal synchronized samples, saturating at the threshold.
   always_comb begin
      stab_nxt = 4'd1;
      if (sync2 == cand)
         stab_nxt = (stab_cnt < STAB_TH) ? stab_cnt + 4'd1 : stab_cnt;
   end

   // Two-flop synchronizer and stability filter. The filter only starts
   // sampling once the synchronizer holds real input data, so the reset
   // contents of the sync flops never count as a stable pattern.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync1     <= 4'd0;
         sync2     <= 4'd0;
         sync_fill <= 2'd0;
         cand      <= 4'd0;
         stab_cnt  <= 4'd0;
         filt      <= 4'd0;
         filt_vld  <= 1'b0;
      end else begin
         sync1 <= PHASE_IN;
         sync2 <= sync1;
         if (sync_fill != 2'd2) begin
            sync_fill <= sync_fill + 2'd1;
         end else begin
            cand     <= sync2;
            stab_cnt <= stab_nxt;
            if (stab_nxt == STAB_TH) begin
               filt     <= sync2;
               filt_vld <= 1'b1;
            end
         end
      end
   end

   // Phase index decode, step distance and saturating period increment.
   always_comb begin
      legal   = 1'b1;
      new_idx = 2'd0;
      case (filt)
         4'b1001: new_idx = 2'd0;
         4'b1010: new_idx = 2'd1;
         4'b0110: new_idx = 2'd2;
         4'b0101: new_idx = 2'd3;
         default: legal = 1'b0;
      endcase
      delta   = new_idx - idx;
      per_inc = (per_cnt == '1) ? per_cnt : per_cnt + PER_ONE;
   end

   // Decoder FSM with registered outputs; CLR_POS overrides everything.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state        <= ST_INIT;
         idx          <= 2'd0;
         first_pend   <= 1'b0;
         per_cnt      <= '0;
         POSITION     <= '0;
         DIR          <= 1'b0;
         STEP_PULSE   <= 1'b0;
         SPEED_PERIOD <= '0;
         LOCKED       <= 1'b0;
         ERR_ILLEGAL  <= 1'b0;
         STALLED      <= 1'b1;
      end else begin
         STEP_PULSE <= 1'b0;
         if (CLR_POS) begin
            state        <= ST_INIT;
            POSITION     <= '0;
            ERR_ILLEGAL  <= 1'b0;
            SPEED_PERIOD <= '0;
            per_cnt      <= '0;
            LOCKED       <= 1'b0;
            STALLED      <= 1'b1;
         end else begin
            case (state)
               ST_INIT: begin
                  if (filt_vld) begin
                     if (legal) begin
                        state      <= ST_TRACK;
                        idx        <= new_idx;
                        first_pend <= 1'b1;
                        LOCKED     <= 1'b1;
                     end else begin
                        state       <= ST_FAULT;
                        ERR_ILLEGAL <= 1'b1;
                     end
                  end
               end
               ST_TRACK: begin
                  if (!legal || delta == 2'd2) begin
                     state       <= ST_FAULT;
                     ERR_ILLEGAL <= 1'b1;
                     LOCKED      <= 1'b0;
                     per_cnt     <= '0;
                     STALLED     <= 1'b1;
                  end else if (delta == 2'd1 || delta == 2'd3) begin
                     POSITION   <= (delta == 2'd1) ? POSITION + POS_W'(1)
                                                   : POSITION - POS_W'(1);
                     DIR        <= (delta == 2'd3);
                     STEP_PULSE <= 1'b1;
                     idx        <= new_idx;
                     if (!first_pend)
                        SPEED_PERIOD <= per_cnt;
                     first_pend <= 1'b0;
                     per_cnt    <= PER_ONE;
                     STALLED    <= (PER_ONE >= STALL_TH);
                  end else begin
                     per_cnt <= per_inc;
                     STALLED <= first_pend || (per_inc >= STALL_TH);
                  end
               end
               ST_FAULT: begin
                  LOCKED  <= 1'b0;
                  STALLED <= 1'b1;
               end
               default: state <= ST_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: vector table, hand-written corner
// sequences and randomized phase traffic, all checked against a cycle model.
module tb_stepper_phase_decoder;

   localparam int POS_W  = 8;
   localparam int PER_W  = 24;
   localparam int S      = 4;
   localparam int STALL  = 50;
   localparam int PERMAX = (1 << PER_W) - 1;

   logic                    CLK = 1'b0;
   logic                    RESET;
   logic [3:0]              PHASE_IN;
   logic                    CLR_POS;
   logic signed [POS_W-1:0] POSITION;
   logic                    DIR;
   logic                    STEP_PULSE;
   logic [PER_W-1:0]        SPEED_PERIOD;
   logic                    LOCKED;
   logic                    ERR_ILLEGAL;
   logic                    STALLED;

   stepper_phase_decoder #(
      .POS_W(POS_W), .PER_W(PER_W), .STABLE_CYC(S), .STALL_CYC(STALL)
   ) dut (
      .CLK(CLK), .RESET(RESET), .PHASE_IN(PHASE_IN), .CLR_POS(CLR_POS),
      .POSITION(POSITION), .DIR(DIR), .STEP_PULSE(STEP_PULSE),
      .SPEED_PERIOD(SPEED_PERIOD), .LOCKED(LOCKED),
      .ERR_ILLEGAL(ERR_ILLEGAL), .STALLED(STALLED)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] pats [4] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};

   // Behavioural model: input history, filtered value, decoder quantities.
   logic [3:0] hist [$];
   int         n_edge;
   logic [3:0] m_filt;
   bit         m_fvld;
   int         m_state;   // 0 unlocked-waiting, 1 tracking, 2 faulted
   int         m_idx, m_pos, m_per, m_speed;
   bit         m_dir, m_err, m_first, m_pulse;

   function automatic int idx_of(input logic [3:0] p);
      for (int i = 0; i < 4; i++)
         if (pats[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      hist.delete();
      n_edge = 0; m_filt = 4'd0; m_fvld = 0; m_state = 0; m_idx = 0;
      m_pos = 0; m_per = 0; m_speed = 0; m_dir = 0; m_err = 0;
      m_first = 0; m_pulse = 0;
   endtask

   task automatic model_edge(input logic [3:0] ph, input logic clr);
      int  ni, d;
      bit  all_eq;
      m_pulse = 0;
      if (clr) begin
         m_state = 0; m_pos = 0; m_err = 0; m_speed = 0; m_per = 0;
      end else if (m_state == 0) begin
         if (m_fvld) begin
            ni = idx_of(m_filt);
            if (ni < 0) begin m_state = 2; m_err = 1; end
            else begin m_state = 1; m_idx = ni; m_first = 1; end
         end
      end else if (m_state == 1) begin
         ni = idx_of(m_filt);
         d  = (ni < 0) ? 2 : (ni - m_idx + 4) % 4;
         if (d == 2) begin
            m_state = 2; m_err = 1; m_per = 0;
         end else if (d == 1 || d == 3) begin
            m_pos   = m_pos + ((d == 1) ? 1 : -1);
            m_dir   = (d == 3);
            m_pulse = 1;
            m_idx   = ni;
            if (!m_first) m_speed = m_per;
            m_first = 0;
            m_per   = 1;
         end else begin
            m_per = (m_per < PERMAX) ? m_per + 1 : PERMAX;
         end
      end
      // The filter sees, at edge n, the input captured at edge n-2; the
      // filtered value follows the last S such samples when they all agree.
      n_edge++;
      hist.push_back(ph);
      if (n_edge >= S + 2) begin
         all_eq = 1;
         for (int k = n_edge - S - 2; k <= n_edge - 3; k++)
            if (hist[k] != hist[n_edge - 3]) all_eq = 0;
         if (all_eq) begin m_filt = hist[n_edge - 3]; m_fvld = 1; end
      end
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // One clock: model follows the edge, all outputs compared on the falling edge.
   task automatic cyc();
      logic [36:0] act_v, exp_v;
      bit          stl;
      @(posedge CLK);
      model_edge(PHASE_IN, CLR_POS);
      @(negedge CLK);
      stl   = (m_state != 1) || m_first || (m_per >= STALL);
      exp_v = {8'(m_pos), m_dir, m_pulse, 24'(m_speed), (m_state == 1), m_err, stl};
      act_v = {POSITION, DIR, STEP_PULSE, SPEED_PERIOD, LOCKED, ERR_ILLEGAL, STALLED};
      check("cycle_model", {27'd0, act_v}, {27'd0, exp_v});
   endtask

   typedef struct {
      logic [3:0] ph;
      logic       clr;
      int         hold;
      int         pos;
      logic       dir;
      logic       lock;
      logic       err;
   } vec_t;

   vec_t tbl [17];
   int   cur;
   int   k;

   initial begin
      tbl[0]  = '{4'b1001, 1'b0, 12, 0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{4'b1010, 1'b0, 12, 1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{4'b0110, 1'b0, 12, 2, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{4'b0101, 1'b0, 12, 3, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{4'b1001, 1'b0, 12, 4, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{4'b0101, 1'b0, 12, 3, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{4'b0110, 1'b0, 12, 2, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{4'b1010, 1'b0,  2, 2, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{4'b0110, 1'b0, 12, 2, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{4'b0000, 1'b0, 12, 2, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{4'b0110, 1'b0, 12, 2, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{4'b0110, 1'b1,  1, 0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{4'b0110, 1'b0,  3, 0, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{4'b1001, 1'b0, 12, 0, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{4'b1001, 1'b1,  1, 0, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{4'b1001, 1'b0,  4, 0, 1'b1, 1'b1, 1'b0};
      tbl[16] = '{4'b1010, 1'b0, 12, 1, 1'b0, 1'b1, 1'b0};

      RESET = 1'b0; PHASE_IN = 4'b1001; CLR_POS = 1'b0;
      model_reset();
      repeat (3) @(negedge CLK);
      check("reset_outputs",
            {27'd0, POSITION, DIR, STEP_PULSE, SPEED_PERIOD, LOCKED, ERR_ILLEGAL, STALLED},
            {27'd0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b1});
      RESET = 1'b1;

      // Vector table
      for (int i = 0; i < 17; i++) begin
         PHASE_IN = tbl[i].ph;
         CLR_POS  = tbl[i].clr;
         repeat (tbl[i].hold) cyc();
         check($sformatf("tbl%0d_pos", i), $unsigned(POSITION), 64'(8'(tbl[i].pos)));
         check($sformatf("tbl%0d_dir", i), DIR, tbl[i].dir);
         check($sformatf("tbl%0d_locked", i), LOCKED, tbl[i].lock);
         check($sformatf("tbl%0d_err", i), ERR_ILLEGAL, tbl[i].err);
      end
      CLR_POS = 1'b0;

      // Step latency: pulse exactly S+3 edges after the first sampling edge
      PHASE_IN = 4'b0110;
      k = 0;
      while (k < 20) begin
         cyc();
         k++;
         if (STEP_PULSE === 1'b1) break;
      end
      check("step_latency", 64'(k), 64'(S + 3));
      repeat (100 - k) cyc();

      // 100-cycle step spacing
      PHASE_IN = 4'b0101;
      repeat (100) cyc();
      PHASE_IN = 4'b1001;
      repeat (7) cyc();
      check("spacing_pulse", STEP_PULSE, 1'b1);
      check("spacing_period", SPEED_PERIOD, 64'd100);
      check("spacing_pos", $unsigned(POSITION), 64'd4);
      check("spacing_dir", DIR, 1'b0);

      // Stall threshold and recovery
      repeat (48) cyc();
      check("stall_before", STALLED, 1'b0);
      cyc();
      check("stall_at", STALLED, 1'b1);
      repeat (24) cyc();
      PHASE_IN = 4'b1010;
      repeat (7) cyc();
      check("stall_recover_pulse", STEP_PULSE, 1'b1);
      check("stall_recover_period", SPEED_PERIOD, 64'd80);
      check("stall_recover_flag", STALLED, 1'b0);
      check("stall_recover_pos", $unsigned(POSITION), 64'd5);

      // CLR_POS on the same edge as a step
      PHASE_IN = 4'b0110;
      repeat (6) cyc();
      CLR_POS = 1'b1;
      cyc();
      check("clr_step_pulse", STEP_PULSE, 1'b0);
      check("clr_step_pos", $unsigned(POSITION), 64'd0);
      check("clr_step_locked", LOCKED, 1'b0);
      CLR_POS = 1'b0;
      cyc();
      check("clr_relock", LOCKED, 1'b1);

      // Position wrap at the signed limits
      cur = 2;
      for (int i = 0; i < 127; i++) begin
         cur = (cur + 1) % 4;
         PHASE_IN = pats[cur];
         repeat (8) cyc();
      end
      check("wrap_max", $unsigned(POSITION), 64'h7f);
      cur = (cur + 1) % 4;
      PHASE_IN = pats[cur];
      repeat (8) cyc();
      check("wrap_min", $unsigned(POSITION), 64'h80);
      cur = (cur + 3) % 4;
      PHASE_IN = pats[cur];
      repeat (8) cyc();
      check("wrap_back", $unsigned(POSITION), 64'h7f);
      check("wrap_back_dir", DIR, 1'b1);

      // Async reset in the middle of a filtered change
      cur = (cur + 1) % 4;
      PHASE_IN = pats[cur];
      repeat (3) cyc();
      #2 RESET = 1'b0;
      #1;
      check("async_reset",
            {27'd0, POSITION, DIR, STEP_PULSE, SPEED_PERIOD, LOCKED, ERR_ILLEGAL, STALLED},
            {27'd0, 8'd0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b1});
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (6) cyc();
      check("relock_early", LOCKED, 1'b0);
      cyc();
      check("relock_at", LOCKED, 1'b1);
      check("relock_stalled", STALLED, 1'b1);

      // Randomized phase traffic against the model
      for (int s = 0; s < 300; s++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            cur = (cur + 1) % 4;
            PHASE_IN = pats[cur];
         end else if (r <= 6) begin
            cur = (cur + 3) % 4;
            PHASE_IN = pats[cur];
         end else if (r == 7) begin
            PHASE_IN = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, S - 1)) cyc();
            PHASE_IN = pats[cur];
         end else if (r == 8) begin
            if ($urandom_range(0, 1) == 1) begin
               cur = (cur + 2) % 4;
               PHASE_IN = pats[cur];
            end else begin
               PHASE_IN = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0011;
            end
         end else begin
            CLR_POS = 1'b1;
            cyc();
            CLR_POS = 1'b0;
         end
         repeat ($urandom_range(1, 14)) cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
